// File: rtl/sb_route_sequencer_if.sv
// Command/handshake bundle between the route sequencer, its host loader and the turn stage.
// The sequencer uses the master view; the host/turn-stage side uses the slave view.
interface sb_route_sequencer_if #(
  parameter int AW = 4
);
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [2:0]    load_data;
  logic [AW:0]   route_len;
  logic          go;
  logic          abort;
  logic          done;
  logic [2:0]    turn;
  logic          start;
  logic [AW-1:0] step_idx;
  logic          busy;
  logic          finished;
  logic          fault;
  logic [1:0]    fault_code;

  modport master (
    input  load_en, load_addr, load_data, route_len, go, abort, done,
    output turn, start, step_idx, busy, finished, fault, fault_code
  );

  modport slave (
    output load_en, load_addr, load_data, route_len, go, abort, done,
    input  turn, start, step_idx, busy, finished, fault, fault_code
  );
endinterface

// File: rtl/sb_route_sequencer.sv
// Replays a stored route of turn codes to the turn stage, one step per stable done,
// with per-step timeout and invalid-code fault detection.
module sb_route_sequencer #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int DONE_STABLE = 8,
  parameter int TIMEOUT     = 50_000_000,
  parameter int SETTLE      = 1000
) (
  input logic                  clk_50,
  input logic                  rst,
  sb_route_sequencer_if.master bus
);
  localparam int SW = $clog2(DONE_STABLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(DONE_STABLE - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [EW-1:0] SETTLE_LAST = EW'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_ISSUE, ST_WAIT, ST_SETTLE, ST_DONE, ST_FAULT
  } state_t;

  state_t        state_r, state_s;
  logic [2:0]    mem_r [DEPTH];
  logic [AW:0]   len_r, len_s;
  logic [AW-1:0] step_r, step_s;
  logic [AW:0]   step_inc_s;
  logic [SW-1:0] stab_r, stab_s;
  logic [TW-1:0] tmo_r, tmo_s;
  logic [EW-1:0] settle_r, settle_s;
  logic [2:0]    turn_r, turn_s;
  logic          start_r, start_s;
  logic [1:0]    fault_code_r, fault_code_s;
  logic [2:0]    fetch_code_s;
  logic          busy_r, finished_r, fault_r;

  function automatic logic code_valid(input logic [2:0] code);
    return (code <= 3'd4);
  endfunction

  // Route memory write port; contents deliberately survive reset.
  always_ff @(posedge clk_50) begin
    if (bus.load_en && (state_r == ST_IDLE)) begin
      mem_r[bus.load_addr] <= bus.load_data;
    end
  end

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    state_s      = state_r;
    len_s        = len_r;
    step_s       = step_r;
    stab_s       = stab_r;
    tmo_s        = tmo_r;
    settle_s     = settle_r;
    turn_s       = turn_r;
    start_s      = start_r;
    fault_code_s = fault_code_r;
    step_inc_s   = {1'b0, step_r} + {{AW{1'b0}}, 1'b1};
    fetch_code_s = mem_r[step_r];
    if (bus.abort) begin
      state_s      = ST_IDLE;
      step_s       = '0;
      stab_s       = '0;
      tmo_s        = '0;
      settle_s     = '0;
      turn_s       = 3'b000;
      start_s      = 1'b0;
      fault_code_s = 2'b00;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bus.go) begin
            len_s   = bus.route_len;
            step_s  = '0;
            turn_s  = 3'b000;
            start_s = 1'b0;
            if (bus.route_len == '0) begin
              state_s      = ST_FAULT;
              fault_code_s = 2'b11;
            end else begin
              state_s = ST_FETCH;
            end
          end else begin
            state_s = state_r;
          end
        end
        ST_FETCH: begin
          if (code_valid(fetch_code_s)) begin
            state_s = ST_ISSUE;
            turn_s  = fetch_code_s;
            start_s = 1'b1;
          end else begin
            state_s      = ST_FAULT;
            fault_code_s = 2'b10;
          end
        end
        ST_ISSUE: begin
          state_s = ST_WAIT;
          stab_s  = '0;
          tmo_s   = '0;
        end
        ST_WAIT: begin
          stab_s = bus.done ? (stab_r + SW'(1)) : '0;
          tmo_s  = tmo_r + TW'(1);
          // Stability is checked first so it wins a same-cycle race with the timeout.
          if (bus.done && (stab_r == STABLE_LAST)) begin
            state_s  = ST_SETTLE;
            settle_s = '0;
            turn_s   = 3'b000;
            start_s  = 1'b0;
          end else if (tmo_r == TMO_LAST) begin
            state_s      = ST_FAULT;
            fault_code_s = 2'b01;
            turn_s       = 3'b000;
            start_s      = 1'b0;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_SETTLE: begin
          if (settle_r == SETTLE_LAST) begin
            settle_s = '0;
            step_s   = step_inc_s[AW-1:0];
            // Full-width compare so a DEPTH-long route finishes instead of wrapping.
            if (step_inc_s == len_r) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_FETCH;
            end
          end else begin
            settle_s = settle_r + EW'(1);
          end
        end
        ST_FAULT: begin
          state_s = ST_FAULT;
        end
        default: begin
          state_s = ST_IDLE;
          turn_s  = 3'b000;
          start_s = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      len_r        <= '0;
      step_r       <= '0;
      stab_r       <= '0;
      tmo_r        <= '0;
      settle_r     <= '0;
      turn_r       <= 3'b000;
      start_r      <= 1'b0;
      fault_code_r <= 2'b00;
      busy_r       <= 1'b0;
      finished_r   <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      len_r        <= len_s;
      step_r       <= step_s;
      stab_r       <= stab_s;
      tmo_r        <= tmo_s;
      settle_r     <= settle_s;
      turn_r       <= turn_s;
      start_r      <= start_s;
      fault_code_r <= fault_code_s;
      busy_r       <= (state_s == ST_FETCH) || (state_s == ST_ISSUE) ||
                      (state_s == ST_WAIT)  || (state_s == ST_SETTLE);
      finished_r   <= (state_s == ST_DONE);
      fault_r      <= (state_s == ST_FAULT);
    end
  end

  assign bus.turn       = turn_r;
  assign bus.start      = start_r;
  assign bus.step_idx   = step_r;
  assign bus.busy       = busy_r;
  assign bus.finished   = finished_r;
  assign bus.fault      = fault_r;
  assign bus.fault_code = fault_code_r;
endmodule
